// File: rtl/sealer_pkg.sv
// Shared definitions for the sealer arbiter: FSM states, sock-type codes
// and the type validity check.
package sealer_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANT   = 3'd1,
      SEAL    = 3'd2,
      RELEASE = 3'd3,
      REJECT  = 3'd4,
      FAULT   = 3'd5
   } state_e;

   localparam logic [2:0] TYPE_BAJO  = 3'b001;
   localparam logic [2:0] TYPE_MEDIO = 3'b100;
   localparam logic [2:0] TYPE_ALTO  = 3'b111;

   // Codes arrive zero-extended so any TYPE_W up to 8 can share this check.
   function automatic logic is_valid_type(input logic [7:0] code);
      return (code == {5'b0, TYPE_BAJO}) || (code == {5'b0, TYPE_MEDIO}) ||
             (code == {5'b0, TYPE_ALTO});
   endfunction

endpackage

// File: rtl/sealer_arbiter_rr_pick.sv
// Rotating priority encoder: first requesting line at or after rr_ptr,
// wrapping modulo N_REQ.
module rr_pick #(
   parameter  int N_REQ = 3,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [IDX_W-1:0] winner,
   output logic             found
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      // Walk from the farthest line back so the nearest requester writes last.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
         if (req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sealer_arbiter.sv
// Shares one sock sealer between N_REQ lines: round-robin grant, seal job
// sequencing with timeout fault, and done/reject pulses back to the winner.
module sealer_arbiter
   import sealer_pkg::*;
#(
   parameter int N_REQ    = 3,
   parameter int SEAL_MAX = 16,
   parameter int TYPE_W   = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*TYPE_W-1:0] type_in,
   input  logic                    stop,
   input  logic                    seal_done,
   input  logic                    fault_clr,
   output logic [N_REQ-1:0]        grant,
   output logic [TYPE_W-1:0]       seal_type,
   output logic                    seal_start,
   output logic                    conv_en,
   output logic [N_REQ-1:0]        done_pulse,
   output logic [N_REQ-1:0]        rej_pulse,
   output logic                    fault
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int TMR_W = $clog2(SEAL_MAX + 1);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d, win_q, win_d, pick_idx, nxt_ptr;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [TYPE_W-1:0]   seal_type_q, seal_type_d, cur_type;
   logic [N_REQ-1:0]    grant_q, grant_d, done_q, done_d, rej_q, rej_d, win_oh;
   logic                seal_start_q, seal_start_d, conv_en_q, conv_en_d;
   logic                fault_q, fault_d, pick_found;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .winner (pick_idx),
      .found  (pick_found)
   );

   assign cur_type = type_in[int'(pick_idx)*TYPE_W +: TYPE_W];
   assign nxt_ptr  = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      win_d       = win_q;
      timer_d     = timer_q;
      seal_type_d = seal_type_q;
      fault_d     = fault_q;
      case (state_q)
         IDLE: if (pick_found && !stop && !fault_q) begin
            win_d       = pick_idx;
            seal_type_d = cur_type;
            timer_d     = '0;
            state_d     = is_valid_type(8'(cur_type)) ? GRANT : REJECT;
         end
         GRANT: begin
            timer_d = timer_q + 1'b1;
            state_d = SEAL;
         end
         // seal_done takes priority over an expiring timer
         SEAL: if (seal_done) begin
            state_d = RELEASE;
         end else if (timer_q == TMR_W'(SEAL_MAX - 1)) begin
            state_d = FAULT;
            fault_d = 1'b1;
         end else begin
            timer_d = timer_q + 1'b1;
         end
         RELEASE, REJECT: begin
            state_d  = IDLE;
            rr_ptr_d = nxt_ptr;
         end
         FAULT: if (fault_clr) begin
            fault_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so decode them from the state being entered.
      win_oh        = '0;
      win_oh[win_d] = 1'b1;
      grant_d       = (state_d inside {GRANT, SEAL, RELEASE}) ? win_oh : '0;
      seal_start_d  = (state_d == GRANT);
      done_d        = (state_d == RELEASE) ? win_oh : '0;
      rej_d         = (state_d == REJECT) ? win_oh : '0;
      conv_en_d     = (state_d == IDLE) && !fault_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         win_q        <= '0;
         timer_q      <= '0;
         seal_type_q  <= '0;
         fault_q      <= 1'b0;
         grant_q      <= '0;
         seal_start_q <= 1'b0;
         done_q       <= '0;
         rej_q        <= '0;
         conv_en_q    <= 1'b1;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         win_q        <= win_d;
         timer_q      <= timer_d;
         seal_type_q  <= seal_type_d;
         fault_q      <= fault_d;
         grant_q      <= grant_d;
         seal_start_q <= seal_start_d;
         done_q       <= done_d;
         rej_q        <= rej_d;
         conv_en_q    <= conv_en_d;
      end
   end

   assign grant      = grant_q;
   assign seal_type  = seal_type_q;
   assign seal_start = seal_start_q;
   assign conv_en    = conv_en_q;
   assign done_pulse = done_q;
   assign rej_pulse  = rej_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_sealer_arbiter.sv
// Scenario bench for sealer_arbiter: directed tasks plus a randomized run,
// all judged against a job-level model of the arbitration rules.
module tb_sealer_arbiter;
   localparam int N  = 3;
   localparam int SM = 16;
   localparam int TW = 3;

   logic            clk = 1'b0;
   logic            reset, stop, seal_done, fault_clr;
   logic [N-1:0]    req;
   logic [TW-1:0]   typ [N];
   logic [N*TW-1:0] type_in;
   logic [N-1:0]    grant, done_pulse, rej_pulse;
   logic [TW-1:0]   seal_type;
   logic            seal_start, conv_en, fault;

   int n_chk  = 0;
   int n_pass = 0;
   int m_ptr  = 0;

   always #5 clk = ~clk;
   assign type_in = {typ[2], typ[1], typ[0]};

   sealer_arbiter #(.N_REQ(N), .SEAL_MAX(SM), .TYPE_W(TW)) dut (
      .clk(clk), .reset(reset), .req(req), .type_in(type_in), .stop(stop),
      .seal_done(seal_done), .fault_clr(fault_clr), .grant(grant),
      .seal_type(seal_type), .seal_start(seal_start), .conv_en(conv_en),
      .done_pulse(done_pulse), .rej_pulse(rej_pulse), .fault(fault)
   );

   // Next line served: first requester at or after the pointer, wrapping.
   function automatic int model_pick(input logic [N-1:0] r, input int ptr);
      for (int k = 0; k < N; k++)
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      return 0;
   endfunction

   function automatic bit model_valid(input logic [2:0] t);
      return t == 3'b001 || t == 3'b100 || t == 3'b111;
   endfunction

   // Starts at a negedge with the DUT idle and inputs set; ends at the
   // negedge where the DUT is idle again after the job.
   task automatic run_job(input int delay, input bit keep, input bit spurious,
                          input bit stop_mid, output int w);
      logic [N-1:0] oh;
      logic [2:0]   t;
      w     = model_pick(req, m_ptr);
      oh    = '0;
      oh[w] = 1'b1;
      t     = typ[w];
      @(negedge clk);
      if (model_valid(t)) begin
         n_chk++;
         if (seal_start !== 1'b1 || grant !== oh || seal_type !== t || rej_pulse !== '0)
            $display("FAIL job_start: start=%b grant=%b type=%b rej=%b, want start=1 grant=%b type=%b rej=000",
                     seal_start, grant, seal_type, rej_pulse, oh, t);
         else n_pass++;
         seal_done = spurious;
         for (int j = 1; j <= delay; j++) begin
            @(negedge clk);
            seal_done = 1'b0;
            if (stop_mid) stop = 1'b1;
            n_chk++;
            if (grant !== oh || seal_start !== 1'b0 || done_pulse !== '0 || fault !== 1'b0)
               $display("FAIL job_seal: cyc=%0d grant=%b start=%b done=%b fault=%b, want grant=%b start=0 done=000 fault=0",
                        j, grant, seal_start, done_pulse, fault, oh);
            else n_pass++;
            if (j == delay) seal_done = 1'b1;
         end
         @(negedge clk);
         seal_done = 1'b0;
         n_chk++;
         if (done_pulse !== oh || grant !== oh || fault !== 1'b0)
            $display("FAIL job_done: done=%b grant=%b fault=%b, want done=%b grant=%b fault=0",
                     done_pulse, grant, fault, oh, oh);
         else n_pass++;
      end else begin
         n_chk++;
         if (rej_pulse !== oh || grant !== '0 || seal_start !== 1'b0)
            $display("FAIL job_reject: rej=%b grant=%b start=%b, want rej=%b grant=000 start=0",
                     rej_pulse, grant, seal_start, oh);
         else n_pass++;
      end
      if (!keep) req[w] = 1'b0;
      m_ptr = (w + 1) % N;
      @(negedge clk);
      n_chk++;
      if (conv_en !== 1'b1 || done_pulse !== '0 || rej_pulse !== '0 || grant !== '0)
         $display("FAIL job_idle: conv_en=%b done=%b rej=%b grant=%b, want 1/000/000/000",
                  conv_en, done_pulse, rej_pulse, grant);
      else n_pass++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_ptr = 0;
   endtask

   task automatic test_reset();
      req = '0; stop = 1'b0; seal_done = 1'b0; fault_clr = 1'b0;
      for (int i = 0; i < N; i++) typ[i] = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++;
      if (grant !== '0 || seal_type !== '0 || seal_start !== 1'b0 || conv_en !== 1'b1 ||
          done_pulse !== '0 || rej_pulse !== '0 || fault !== 1'b0)
         $display("FAIL reset_vals: grant=%b type=%b start=%b conv=%b done=%b rej=%b fault=%b, want 000/000/0/1/000/000/0",
                  grant, seal_type, seal_start, conv_en, done_pulse, rej_pulse, fault);
      else n_pass++;
      reset = 1'b0;
      m_ptr = 0;
      @(negedge clk);
      n_chk++;
      if (conv_en !== 1'b1 || seal_start !== 1'b0)
         $display("FAIL reset_idle: conv_en=%b start=%b, want 1/0", conv_en, seal_start);
      else n_pass++;
   endtask

   task automatic test_single();
      int w;
      typ[0] = 3'b001;
      req    = 3'b001;
      run_job(3, 1'b0, 1'b0, 1'b0, w);
      req = '0;
   endtask

   task automatic test_round_robin();
      int w;
      do_reset();
      typ[0] = 3'b111; typ[1] = 3'b001; typ[2] = 3'b100;
      req = 3'b111;
      for (int i = 0; i < 4; i++) run_job(2, 1'b1, 1'b0, 1'b0, w);
      req = '0;
   endtask

   task automatic test_invalid();
      int w;
      typ[1] = 3'b010;
      req    = 3'b010;
      run_job(1, 1'b0, 1'b0, 1'b0, w);
      typ[1] = 3'b111;
      req    = 3'b111;
      run_job(2, 1'b0, 1'b0, 1'b0, w);
      req = '0;
   endtask

   task automatic test_timeout();
      int w;
      typ[0] = 3'b100;
      req    = 3'b001;
      @(negedge clk);
      n_chk++;
      if (seal_start !== 1'b1 || grant !== 3'b001)
         $display("FAIL to_start: start=%b grant=%b, want 1/001", seal_start, grant);
      else n_pass++;
      for (int j = 1; j <= SM - 1; j++) begin
         @(negedge clk);
         if (j == 8) begin
            typ[1] = 3'b111; typ[2] = 3'b001;
            req = 3'b111;
         end
         n_chk++;
         if (fault !== 1'b0 || grant !== 3'b001)
            $display("FAIL to_wait: cyc=%0d fault=%b grant=%b, want 0/001", j, fault, grant);
         else n_pass++;
      end
      @(negedge clk);
      n_chk++;
      if (fault !== 1'b1 || conv_en !== 1'b0 || grant !== '0)
         $display("FAIL to_fault: fault=%b conv_en=%b grant=%b, want 1/0/000", fault, conv_en, grant);
      else n_pass++;
      repeat (3) begin
         @(negedge clk);
         n_chk++;
         if (fault !== 1'b1 || seal_start !== 1'b0 || grant !== '0 || conv_en !== 1'b0)
            $display("FAIL to_hold: fault=%b start=%b grant=%b conv=%b, want 1/0/000/0",
                     fault, seal_start, grant, conv_en);
         else n_pass++;
      end
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      n_chk++;
      if (fault !== 1'b0 || conv_en !== 1'b1)
         $display("FAIL to_clear: fault=%b conv_en=%b, want 0/1", fault, conv_en);
      else n_pass++;
      run_job(4, 1'b0, 1'b0, 1'b0, w);
      req = '0;
   endtask

   task automatic test_stop();
      int w;
      typ[0] = 3'b111; typ[1] = 3'b100; typ[2] = 3'b001;
      req = 3'b011;
      run_job(5, 1'b0, 1'b0, 1'b1, w);
      repeat (3) begin
         @(negedge clk);
         n_chk++;
         if (seal_start !== 1'b0 || grant !== '0 || conv_en !== 1'b1)
            $display("FAIL stop_block: start=%b grant=%b conv=%b, want 0/000/1", seal_start, grant, conv_en);
         else n_pass++;
      end
      stop = 1'b0;
      run_job(2, 1'b0, 1'b0, 1'b0, w);
      req = '0;
   endtask

   task automatic test_race();
      int w;
      typ[1] = 3'b001;
      req    = 3'b010;
      run_job(SM - 1, 1'b0, 1'b0, 1'b0, w);
      req = '0;
   endtask

   task automatic test_reset_mid();
      typ[2] = 3'b111;
      req    = 3'b100;
      @(negedge clk);
      n_chk++;
      if (seal_start !== 1'b1 || seal_type !== 3'b111)
         $display("FAIL rstmid_start: start=%b type=%b, want 1/111", seal_start, seal_type);
      else n_pass++;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_chk++;
      if (grant !== '0 || seal_type !== '0 || done_pulse !== '0 || seal_start !== 1'b0 ||
          conv_en !== 1'b1 || fault !== 1'b0)
         $display("FAIL rstmid_vals: grant=%b type=%b done=%b start=%b conv=%b fault=%b, want 000/000/000/0/1/0",
                  grant, seal_type, done_pulse, seal_start, conv_en, fault);
      else n_pass++;
      req   = '0;
      reset = 1'b0;
      m_ptr = 0;
      @(negedge clk);
      n_chk++;
      if (done_pulse !== '0 || grant !== '0)
         $display("FAIL rstmid_after: done=%b grant=%b, want 000/000", done_pulse, grant);
      else n_pass++;
   endtask

   task automatic test_random();
      int w;
      logic [2:0] vals [3];
      vals[0] = 3'b001; vals[1] = 3'b100; vals[2] = 3'b111;
      for (int it = 0; it < 60; it++) begin
         req = req | N'($urandom_range(0, 7));
         if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
         for (int i = 0; i < N; i++)
            typ[i] = ($urandom_range(0, 3) != 0) ? vals[$urandom_range(0, 2)]
                                                : 3'($urandom_range(0, 7));
         run_job($urandom_range(1, SM - 1), 1'b0, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), w);
         if (stop) begin
            repeat ($urandom_range(1, 3)) begin
               @(negedge clk);
               n_chk++;
               if (seal_start !== 1'b0 || grant !== '0)
                  $display("FAIL rand_stop: start=%b grant=%b, want 0/000", seal_start, grant);
               else n_pass++;
            end
            stop = 1'b0;
         end
      end
      req = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_invalid();
      test_timeout();
      test_stop();
      test_race();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
